motor_pwm_drive: RTL and testbench

MOTOR_PWM_DRIVE -- requirements
Module: motor_pwm_drive

---
 rtl/motor_pwm_drive_if.sv | 21 ++
 rtl/motor_pwm_drive.sv | 167 ++++++++++++++++
 tb/tb_motor_pwm_drive.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/motor_pwm_drive_if.sv
// Command/status bundle between the position loop and the H-bridge PWM driver.
interface motor_pwm_drive_if;
   logic        enable;
   logic [11:0] errorabs;
   logic        errorsign;
   logic        pwm_out;
   logic        dir_out;
   logic        brake;
   logic        in_pos;
   logic        period_start;

   modport master (
      output enable, errorabs, errorsign,
      input  pwm_out, dir_out, brake, in_pos, period_start
   );

   modport slave (
      input  enable, errorabs, errorsign,
      output pwm_out, dir_out, brake, in_pos, period_start
   );
endinterface

// File: rtl/motor_pwm_drive.sv
// H-bridge PWM generator: proportional duty from the position error, deadband
// for in-position, and a braked dwell before every direction reversal.
module motor_pwm_drive #(
   parameter int unsigned PWM_PERIOD = 1200,
   parameter int unsigned KP_SHIFT   = 3,
   parameter int unsigned DEADBAND   = 2,
   parameter int unsigned DIR_DEAD   = 480
) (
   input  logic             clk_48,
   input  logic             reset_n,
   motor_pwm_drive_if.slave drv
);

   localparam int unsigned CNT_W  = 11;
   localparam int unsigned ERR_W  = 12;
   localparam int unsigned FULL_W = ERR_W + KP_SHIFT;
   localparam int unsigned DWL_W  = 12;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PWM_PERIOD - 1);
   localparam logic [CNT_W-1:0] DUTY_MAX = CNT_W'(PWM_PERIOD);
   localparam logic [DWL_W-1:0] DWL_LAST = DWL_W'(DIR_DEAD - 1);
   localparam logic [ERR_W-1:0] DB_LIM   = ERR_W'(DEADBAND);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_SWITCH = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic [CNT_W-1:0]    r_cnt;
   logic [CNT_W-1:0]    w_cnt_next;
   logic                w_start;
   logic [CNT_W-1:0]    r_duty;
   logic [CNT_W-1:0]    w_duty_next;
   logic [CNT_W-1:0]    w_duty_req;
   logic [FULL_W-1:0]   w_scaled;
   logic                w_in_db;
   logic                r_sign;
   logic                w_sign_next;
   logic [DWL_W-1:0]    r_dwell;
   logic [DWL_W-1:0]    w_dwell_next;
   logic                w_dwell_done;
   logic                r_pwm_out;
   logic                r_dir_out;
   logic                r_brake;
   logic                r_in_pos;
   logic                r_period_start;
   logic                w_pwm_next;
   logic                w_dir_next;
   logic                w_brake_next;

   // w_start flags that the cycle after this edge is a period start (counter == 0)
   assign w_cnt_next = (r_cnt == CNT_LAST) ? '0 : r_cnt + CNT_W'(1);
   assign w_start    = (w_cnt_next == '0);

   // Requested duty: saturate at full width so large errors cannot wrap
   assign w_in_db    = (drv.errorabs <= DB_LIM);
   assign w_scaled   = FULL_W'(drv.errorabs) << KP_SHIFT;
   assign w_duty_req = w_in_db                           ? '0       :
                       (w_scaled > FULL_W'(PWM_PERIOD)) ? DUTY_MAX :
                                                          w_scaled[CNT_W-1:0];

   assign w_dwell_done = (r_state == ST_SWITCH) && (r_dwell == DWL_LAST);

   // State register
   always_ff @(posedge clk_48 or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic; enable low overrides everything
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_start) begin
               w_state_next = ST_RUN;
            end
         end
         ST_RUN: begin
            if (w_start && (w_duty_req != '0) && (drv.errorsign != r_dir_out)) begin
               w_state_next = ST_SWITCH;
            end
         end
         ST_SWITCH: begin
            if (w_dwell_done) begin
               w_state_next = ST_RUN;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
      if (!drv.enable) begin
         w_state_next = ST_IDLE;
      end
   end

   // Datapath and output next values; the first RUN period after IDLE or a reversal runs at zero duty
   always_comb begin
      w_duty_next  = r_duty;
      w_sign_next  = w_start ? drv.errorsign : r_sign;
      w_dir_next   = r_dir_out;
      w_dwell_next = '0;
      case (r_state)
         ST_RUN: begin
            if (w_start) begin
               w_duty_next = w_duty_req;
            end
         end
         ST_SWITCH: begin
            if (w_dwell_done) begin
               w_duty_next = '0;
               w_dir_next  = r_sign;
            end else begin
               w_dwell_next = r_dwell + DWL_W'(1);
               if (w_start) begin
                  w_duty_next = w_duty_req;
               end
            end
         end
         default: w_duty_next = '0;
      endcase
      if (!drv.enable) begin
         w_duty_next  = '0;
         w_dwell_next = '0;
         w_dir_next   = r_dir_out;
      end
      w_pwm_next   = (w_state_next == ST_RUN) && (w_cnt_next < w_duty_next);
      w_brake_next = (w_state_next == ST_SWITCH);
   end

   // Counter, latched duty/sign, dwell and registered outputs
   always_ff @(posedge clk_48 or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt          <= '0;
         r_duty         <= '0;
         r_sign         <= 1'b0;
         r_dwell        <= '0;
         r_pwm_out      <= 1'b0;
         r_dir_out      <= 1'b0;
         r_brake        <= 1'b0;
         r_in_pos       <= 1'b0;
         r_period_start <= 1'b0;
      end else begin
         r_cnt          <= w_cnt_next;
         r_duty         <= w_duty_next;
         r_sign         <= w_sign_next;
         r_dwell        <= w_dwell_next;
         r_pwm_out      <= w_pwm_next;
         r_dir_out      <= w_dir_next;
         r_brake        <= w_brake_next;
         r_in_pos       <= w_in_db;
         r_period_start <= w_start;
      end
   end

   assign drv.pwm_out      = r_pwm_out;
   assign drv.dir_out      = r_dir_out;
   assign drv.brake        = r_brake;
   assign drv.in_pos       = r_in_pos;
   assign drv.period_start = r_period_start;

endmodule

// File: tb/tb_motor_pwm_drive.sv
// Scoreboard bench for motor_pwm_drive: per-period expectations are queued by
// the stimulus and checked by a monitor at every period_start.
module tb_motor_pwm_drive;

   localparam int PP = 1200;

   typedef struct {
      int idx;
      int hi;
      int brk;
      int dir;
      int inpos;
   } exp_t;

   logic clk_48 = 1'b0;
   logic reset_n;

   motor_pwm_drive_if bus ();

   motor_pwm_drive #(
      .PWM_PERIOD (1200),
      .KP_SHIFT   (3),
      .DEADBAND   (2),
      .DIR_DEAD   (480)
   ) dut (
      .clk_48  (clk_48),
      .reset_n (reset_n),
      .drv     (bus)
   );

   always #5 clk_48 = ~clk_48;

   exp_t sb_q[$];
   int   total = 0;
   int   bad   = 0;

   int   mon_idx    = 0;
   int   acc_hi     = 0;
   int   acc_brk    = 0;
   int   acc_ovl    = 0;
   int   acc_dirchg = 0;
   int   acc_inpos  = 0;
   int   acc_dir    = 0;
   logic prev_dir   = 1'b0;
   logic prev_pwm   = 1'b0;

   function automatic void chk(string name, int act, int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endfunction

   function automatic void push(int idx, int hi, int brk, int dir, int inpos);
      exp_t e;
      e.idx = idx; e.hi = hi; e.brk = brk; e.dir = dir; e.inpos = inpos;
      sb_q.push_back(e);
   endfunction

   // Monitor: accumulate each period, compare against the queued expectation at its end
   always @(negedge clk_48) begin : monitor
      exp_t e;
      if (bus.period_start) begin
         if (mon_idx > 0) begin
            while (sb_q.size() > 0 && sb_q[0].idx < mon_idx) begin
               chk("missed_period", sb_q[0].idx, mon_idx);
               void'(sb_q.pop_front());
            end
            if (sb_q.size() > 0 && sb_q[0].idx == mon_idx) begin
               e = sb_q.pop_front();
               chk($sformatf("p%0d_pwm_high_cycles", mon_idx), acc_hi, e.hi);
               chk($sformatf("p%0d_brake_cycles", mon_idx), acc_brk, e.brk);
               chk($sformatf("p%0d_dir_at_end", mon_idx), acc_dir, e.dir);
               chk($sformatf("p%0d_in_pos_at_start", mon_idx), acc_inpos, e.inpos);
               chk($sformatf("p%0d_pwm_and_brake", mon_idx), acc_ovl, 0);
               chk($sformatf("p%0d_dir_change_with_pwm", mon_idx), acc_dirchg, 0);
            end
         end
         mon_idx++;
         acc_hi     = 0;
         acc_brk    = 0;
         acc_ovl    = 0;
         acc_dirchg = 0;
         acc_inpos  = int'(bus.in_pos);
      end
      acc_hi  += int'(bus.pwm_out);
      acc_brk += int'(bus.brake);
      if (bus.pwm_out && bus.brake) acc_ovl++;
      if ((bus.dir_out != prev_dir) && (bus.pwm_out || prev_pwm)) acc_dirchg++;
      acc_dir  = int'(bus.dir_out);
      prev_dir = bus.dir_out;
      prev_pwm = bus.pwm_out;
   end

   task automatic wait_start();
      int n = 0;
      do begin
         @(negedge clk_48);
         n++;
      end while (!bus.period_start && n < 2 * PP);
      if (!bus.period_start) chk("period_start_timeout", n, PP);
   endtask

   task automatic measure_first(string name);
      int n = 0;
      do begin
         @(negedge clk_48);
         n++;
      end while (!bus.period_start && n < 2 * PP);
      chk(name, n, PP);
   endtask

   task automatic mid();
      repeat (600) @(negedge clk_48);
   endtask

   task automatic chk_all_zero(string tag);
      chk({tag, "_pwm_out"}, int'(bus.pwm_out), 0);
      chk({tag, "_dir_out"}, int'(bus.dir_out), 0);
      chk({tag, "_brake"}, int'(bus.brake), 0);
      chk({tag, "_in_pos"}, int'(bus.in_pos), 0);
      chk({tag, "_period_start"}, int'(bus.period_start), 0);
   endtask

   initial begin : watchdog
      repeat (60000) @(posedge clk_48);
      $display("FAIL watchdog: cycle budget exhausted, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      reset_n       = 1'b0;
      bus.enable    = 1'b0;
      bus.errorabs  = 12'd0;
      bus.errorsign = 1'b0;
      repeat (3) @(negedge clk_48);
      chk_all_zero("reset");
      reset_n = 1'b1;

      // P1: still disabled
      measure_first("first_start_after_reset");
      push(1, 0, 0, 0, 1);
      push(2, 0, 0, 0, 0);
      push(3, 800, 0, 0, 0);
      push(4, 800, 0, 0, 0);
      mid();
      bus.enable   = 1'b1;
      bus.errorabs = 12'd100;
      wait_start();
      wait_start();
      wait_start();

      // P4: saturation
      push(5, 1200, 0, 0, 0);
      push(6, 1200, 0, 0, 0);
      push(7, 0, 0, 0, 1);
      mid();
      bus.errorabs = 12'd200;
      wait_start();
      wait_start();

      // P6: deadband edge
      mid();
      bus.errorabs = 12'd2;
      wait_start();

      // P7: leave deadband, in_pos latency
      push(8, 24, 0, 0, 0);
      mid();
      chk("in_pos_in_deadband", int'(bus.in_pos), 1);
      bus.errorabs = 12'd3;
      #1;
      chk("in_pos_before_edge", int'(bus.in_pos), 1);
      @(negedge clk_48);
      chk("in_pos_after_edge", int'(bus.in_pos), 0);
      wait_start();

      // P8: opposite sign with zero duty
      push(9, 0, 0, 0, 1);
      mid();
      bus.errorabs  = 12'd1;
      bus.errorsign = 1'b1;
      wait_start();

      // P9: forward drive again
      push(10, 400, 0, 0, 0);
      mid();
      bus.errorabs  = 12'd50;
      bus.errorsign = 1'b0;
      wait_start();

      // P10: reversal request
      push(11, 0, 480, 1, 0);
      push(12, 400, 0, 1, 0);
      mid();
      bus.errorsign = 1'b1;
      wait_start();
      wait_start();

      // P12: reversal back, aborted by enable 100 cycles into the dwell
      push(13, 0, 101, 1, 0);
      push(14, 0, 0, 1, 0);
      mid();
      bus.errorsign = 1'b0;
      wait_start();
      repeat (100) @(negedge clk_48);
      bus.enable = 1'b0;
      @(negedge clk_48);
      chk("disable_brake", int'(bus.brake), 0);
      chk("disable_dir_held", int'(bus.dir_out), 1);
      chk("disable_pwm", int'(bus.pwm_out), 0);
      wait_start();

      // P14: re-enable; direction mismatch triggers a full reversal in P16
      push(15, 0, 0, 1, 0);
      push(16, 0, 480, 0, 0);
      push(17, 400, 0, 0, 0);
      mid();
      bus.enable = 1'b1;
      wait_start();
      wait_start();
      wait_start();
      wait_start();

      // P18: asynchronous reset while driving
      repeat (10) @(negedge clk_48);
      chk("pre_reset_pwm_high", int'(bus.pwm_out), 1);
      #2;
      reset_n = 1'b0;
      #1;
      chk_all_zero("async_reset");
      @(negedge clk_48);
      reset_n = 1'b1;
      measure_first("first_start_after_pulse");

      repeat (5) @(negedge clk_48);
      chk("scoreboard_drained", sb_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
